// File: rtl/quad_decoder.sv
// x4 quadrature decoder: synchronizes and deglitches A/B, then tracks position,
// direction, step strobe, step period and illegal (double-bit) transitions.
module quad_decoder #(
  parameter int COUNT_WIDTH  = 16,
  parameter int PERIOD_WIDTH = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          a_in,
  input  logic                          b_in,
  input  logic                          clear,
  input  logic                          err_clr,
  output logic signed [COUNT_WIDTH-1:0] count,
  output logic                          dir,
  output logic                          step,
  output logic                          error,
  output logic        [PERIOD_WIDTH-1:0] period,
  output logic                          period_valid,
  output logic                          stalled
);

  localparam int SETTLE = SYNC_STAGES + FILTER_LEN;
  localparam int SET_W  = $clog2(SETTLE + 1);
  localparam int FLT_W  = $clog2(FILTER_LEN + 1);
  localparam logic        [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;
  localparam logic signed [COUNT_WIDTH-1:0]  COUNT_ONE  = 1;

  function automatic logic [PERIOD_WIDTH-1:0] sat_inc(input logic [PERIOD_WIDTH-1:0] v);
    return (v == PERIOD_MAX) ? v : v + 1'b1;
  endfunction

  // Returns {next filtered level, next persistence count}.
  function automatic logic [FLT_W:0] filt_next(input logic s, input logic f,
                                               input logic [FLT_W-1:0] c);
    if (s == f)
      return {f, FLT_W'(0)};
    if (c == FLT_W'(FILTER_LEN - 1))
      return {s, FLT_W'(0)};
    return {f, c + 1'b1};
  endfunction

  logic [SYNC_STAGES-1:0] a_sync_p0, b_sync_p0;
  logic                   a_filt_p1, b_filt_p1;
  logic [FLT_W-1:0]       a_fcnt_p1, b_fcnt_p1;
  logic [FLT_W:0]         a_fnxt, b_fnxt;
  logic [1:0]             ab_prev_p2, ab_cur, ab_diff;
  logic [SET_W-1:0]       settle_cnt;
  logic [PERIOD_WIDTH-1:0] run_cnt;
  logic                   settled, a_sync, b_sync;
  logic                   mv_up, mv_dn, mv_bad;

  assign a_sync  = a_sync_p0[SYNC_STAGES-1];
  assign b_sync  = b_sync_p0[SYNC_STAGES-1];
  assign settled = (settle_cnt == SET_W'(SETTLE));
  assign a_fnxt  = filt_next(a_sync, a_filt_p1, a_fcnt_p1);
  assign b_fnxt  = filt_next(b_sync, b_filt_p1, b_fcnt_p1);

  // Stage p0: synchronizer chains; settle counter gates decoding after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sync_p0  <= '0;
      b_sync_p0  <= '0;
      settle_cnt <= '0;
    end else begin
      a_sync_p0 <= {a_sync_p0[SYNC_STAGES-2:0], a_in};
      b_sync_p0 <= {b_sync_p0[SYNC_STAGES-2:0], b_in};
      if (!settled)
        settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // Stage p1: deglitch filters; prev tracks sync while settling so no false step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_filt_p1  <= 1'b0;
      b_filt_p1  <= 1'b0;
      a_fcnt_p1  <= '0;
      b_fcnt_p1  <= '0;
      ab_prev_p2 <= 2'b00;
    end else if (!settled) begin
      a_filt_p1  <= a_sync;
      b_filt_p1  <= b_sync;
      a_fcnt_p1  <= '0;
      b_fcnt_p1  <= '0;
      ab_prev_p2 <= {a_sync, b_sync};
    end else begin
      {a_filt_p1, a_fcnt_p1} <= a_fnxt;
      {b_filt_p1, b_fcnt_p1} <= b_fnxt;
      ab_prev_p2             <= ab_cur;
    end
  end

  // Up when the new B differs from the old A (Gray sequence 00,01,11,10).
  assign ab_cur  = {a_filt_p1, b_filt_p1};
  assign ab_diff = ab_prev_p2 ^ ab_cur;
  assign mv_bad  = settled && (ab_diff == 2'b11);
  assign mv_up   = settled && (^ab_diff) && (ab_cur[0] != ab_prev_p2[1]);
  assign mv_dn   = settled && (^ab_diff) && (ab_cur[0] == ab_prev_p2[1]);

  // Stage p2: position, direction, error and period outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      dir          <= 1'b0;
      step         <= 1'b0;
      error        <= 1'b0;
      period       <= PERIOD_MAX;
      period_valid <= 1'b0;
      run_cnt      <= PERIOD_MAX;
    end else begin
      if (clear)
        count <= '0;
      else if (mv_up)
        count <= count + COUNT_ONE;
      else if (mv_dn)
        count <= count - COUNT_ONE;
      if (mv_up)
        dir <= 1'b0;
      else if (mv_dn)
        dir <= 1'b1;
      step         <= mv_up | mv_dn;
      period_valid <= mv_up | mv_dn;
      error        <= mv_bad | (error & ~err_clr);
      if (mv_up | mv_dn) begin
        period  <= run_cnt;
        run_cnt <= PERIOD_WIDTH'(1);
      end else begin
        run_cnt <= sat_inc(run_cnt);
      end
    end
  end

  assign stalled = (run_cnt == PERIOD_MAX);

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: timestamp/Gray-position reference model checked every
// cycle, plus directed scenarios with hand-computed expectations and random moves.
module tb_quad_decoder;
  localparam int CW = 16, PW = 16, SS = 2, FL = 4;
  localparam int SETTLE = SS + FL;
  localparam int PMAX = 65535;

  logic clk = 0, reset = 1, a_in = 0, b_in = 0, clear = 0, err_clr = 0;
  logic signed [CW-1:0] count;
  logic dir, step, error, period_valid, stalled;
  logic [PW-1:0] period;

  int checks = 0, errors = 0;
  bit mdl_on = 0;
  int n_steps = 0;

  always #5 clk = ~clk;

  quad_decoder #(.COUNT_WIDTH(CW), .PERIOD_WIDTH(PW), .SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .clear(clear), .err_clr(err_clr),
    .count(count), .dir(dir), .step(step), .error(error), .period(period),
    .period_valid(period_valid), .stalled(stalled)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int g2p(input bit [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit [1:0] p2g(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Reference model: raw samples delayed by the synchronizer depth, a level is
  // accepted once FL consecutive observed samples all disagree with it, steps
  // decoded from Gray positions, period from step timestamps.
  int m_edges, m_last_step;
  bit m_any_step;
  bit qa[$], qb[$], ha[$], hb[$];
  bit m_fa, m_fb;
  bit [1:0] m_prev;
  bit [15:0] m_count;
  bit m_dir, m_step, m_err, m_pv, m_stall;
  int m_period;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edges = 0; m_last_step = 0; m_any_step = 0;
      qa.delete(); qb.delete(); ha.delete(); hb.delete();
      m_fa = 0; m_fb = 0; m_prev = 2'b00;
      m_count = 0; m_dir = 0; m_step = 0; m_err = 0; m_pv = 0; m_stall = 1; m_period = PMAX;
    end else begin : mstep
      bit sa, sb, up, dn, bad, oka, okb;
      int d;
      m_edges++;
      sa = (qa.size() >= SS) ? qa[SS-1] : 1'b0;
      sb = (qb.size() >= SS) ? qb[SS-1] : 1'b0;
      qa.push_front(a_in); qb.push_front(b_in);
      if (qa.size() > SS) begin void'(qa.pop_back()); void'(qb.pop_back()); end
      up = 0; dn = 0; bad = 0;
      if (m_edges > SETTLE) begin
        d = (g2p({m_fa, m_fb}) - g2p(m_prev) + 4) % 4;
        up = (d == 1); dn = (d == 3); bad = (d == 2);
        m_prev = {m_fa, m_fb};
        ha.push_front(sa); hb.push_front(sb);
        if (ha.size() > FL) begin void'(ha.pop_back()); void'(hb.pop_back()); end
        oka = (ha.size() == FL); okb = (hb.size() == FL);
        foreach (ha[i]) if (ha[i] == m_fa) oka = 0;
        foreach (hb[i]) if (hb[i] == m_fb) okb = 0;
        if (oka) m_fa = sa;
        if (okb) m_fb = sb;
      end else begin
        m_prev = {sa, sb}; m_fa = sa; m_fb = sb;
        ha.delete(); hb.delete();
      end
      m_step = up | dn;
      m_pv = m_step;
      if (clear) m_count = 0;
      else if (up) m_count = m_count + 16'd1;
      else if (dn) m_count = m_count - 16'd1;
      if (up) m_dir = 0;
      else if (dn) m_dir = 1;
      m_err = bad | (m_err & !err_clr);
      if (m_step) begin
        m_period = m_any_step ? ((m_edges - m_last_step > PMAX) ? PMAX : m_edges - m_last_step) : PMAX;
        m_any_step = 1;
        m_last_step = m_edges;
      end
      m_stall = !m_any_step || (m_edges - m_last_step + 1 >= PMAX);
    end
  end

  always @(negedge clk) begin
    if (step === 1'b1) n_steps++;
    if (mdl_on) begin
      chk("count", $unsigned(count), m_count);
      chk("dir", dir, m_dir);
      chk("step", step, m_step);
      chk("error", error, m_err);
      chk("period", period, m_period);
      chk("period_valid", period_valid, m_pv);
      chk("stalled", stalled, m_stall);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: apply a level change, wait (bounded) for the step,
  // check latency and optionally period, then complete a 10-cycle hold.
  task automatic go(input bit a, input bit b, input int exp_p, input string nm);
    int k;
    a_in = a; b_in = b; k = 0;
    while (step !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, k, 7);
    if (exp_p >= 0) chk({nm, "_period"}, period, exp_p);
    tick(10 - k);
  endtask

  task automatic pulse_reset(input bit a, input bit b);
    @(negedge clk);
    a_in = a; b_in = b;
    #2 reset = 1;
    tick(2);
    reset = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n0;
    bit [1:0] cur, nxt;
    // 1: reset with both inputs high, never a step or error
    a_in = 1; b_in = 1;
    tick(3);
    reset = 0;
    mdl_on = 1;
    tick(6);
    chk("t1_error", error, 0);
    chk("t1_count", $unsigned(count), 0);
    chk("t1_step", step, 0);
    chk("t1_period", period, 16'hFFFF);
    chk("t1_stalled", stalled, 1);
    tick(6);
    chk("t1_nsteps", n_steps, 0);

    // 2: forward x4 sequence, 10 clk per level
    pulse_reset(0, 0);
    tick(12);
    go(0, 1, 16'hFFFF, "t2_s1");
    go(1, 1, 10, "t2_s2");
    go(1, 0, 10, "t2_s3");
    go(0, 0, 10, "t2_s4");
    chk("t2_count", $unsigned(count), 4);
    chk("t2_dir", dir, 0);

    // 3: clear then 8 down steps
    clear = 1; tick(1); clear = 0;
    chk("t3_cleared", $unsigned(count), 0);
    for (int i = 0; i < 2; i++) begin
      go(1, 0, -1, "t3_d");
      go(1, 1, -1, "t3_d");
      go(0, 1, -1, "t3_d");
      go(0, 0, -1, "t3_d");
    end
    chk("t3_count", $unsigned(count), 16'hFFF8);
    chk("t3_dir", dir, 1);
    chk("t3_error", error, 0);

    // 4: glitch filter boundary
    s0 = count; n0 = n_steps;
    a_in = 1; tick(3); a_in = 0; tick(15);
    chk("t4_short_steps", n_steps - n0, 0);
    chk("t4_short_count", $unsigned(count), s0[15:0]);
    a_in = 1; tick(4); a_in = 0; tick(15);
    chk("t4_long_steps", n_steps - n0, 2);
    chk("t4_long_count", $unsigned(count), s0[15:0]);

    // 5: illegal double change, then error clear
    s0 = count;
    a_in = 1; b_in = 1; tick(15);
    chk("t5_error", error, 1);
    chk("t5_count", $unsigned(count), s0[15:0]);
    a_in = 0; b_in = 0; tick(15);
    err_clr = 1; tick(1); err_clr = 0;
    chk("t5_err_clr", error, 0);

    // 6: clear coincident with step
    a_in = 1;
    tick(6);
    chk("t6_pre_step", step, 0);
    clear = 1; tick(1); clear = 0;
    chk("t6_step", step, 1);
    chk("t6_count", $unsigned(count), 0);
    chk("t6_dir", dir, 1);
    // reset mid-run takes effect immediately
    #2 reset = 1;
    #1;
    chk("t6_rst_count", $unsigned(count), 0);
    chk("t6_rst_dir", dir, 0);
    chk("t6_rst_step", step, 0);
    chk("t6_rst_error", error, 0);
    chk("t6_rst_period", period, 16'hFFFF);
    chk("t6_rst_pv", period_valid, 0);
    chk("t6_rst_stalled", stalled, 1);
    tick(1);
    reset = 0;
    tick(12);
    go(0, 0, 16'hFFFF, "t6_first");
    chk("t6_count_up", $unsigned(count), 1);
    chk("t6_not_stalled", stalled, 0);
    tick(65540);
    chk("t6_stalled", stalled, 1);

    // random moves, glitches, illegal jumps and clears
    for (int i = 0; i < 400; i++) begin
      int r, hold;
      r = $urandom_range(0, 99);
      hold = $urandom_range(1, 14);
      cur = {a_in, b_in};
      if (r < 40)      nxt = p2g(g2p(cur) + 1);
      else if (r < 80) nxt = p2g(g2p(cur) + 3);
      else if (r < 90) nxt = cur ^ 2'b11;
      else             nxt = cur ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
      a_in = nxt[1]; b_in = nxt[0];
      clear = ($urandom_range(0, 19) == 0);
      err_clr = ($urandom_range(0, 9) == 0);
      tick(1);
      clear = 0; err_clr = 0;
      tick(hold - 1);
    end
    tick(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
